// File: rtl/zrb_bt_cmd_parser.sv
// -----------------------------------------------------------------------------
// zrb_bt_cmd_parser
//
// Pops bytes from the RX byte FIFO and assembles ASCII command lines of the
// form <letter><hex digits><CR|LF>. Each well-formed line is presented to the
// controller over a valid/ready handshake. Malformed lines produce a one-cycle
// error strobe with a held reason code.
//
// Optional feature macro: ZRB_BT_CMD_ECHO_EN
//   When defined, every received byte is echoed to the TX FIFO. Parsing stalls
//   while the TX FIFO is full. When undefined, tx_wr/tx_data are tied to 0 and
//   tx_full is ignored.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   fifo_data  in   RX FIFO data_out (valid the cycle after fifo_rd)
//   fifo_empty in   RX FIFO empty flag
//   fifo_rd    out  RX FIFO read_enable, one-cycle pulse
//   cmd_valid  out  decoded command available
//   cmd_ready  in   consumer accepts the command
//   cmd_code   out  command letter, folded to uppercase
//   cmd_arg    out  argument, right-justified, zero-extended
//   cmd_ndig   out  number of hex digits received (0 = no argument)
//   cmd_err    out  one-cycle error pulse
//   err_code   out  01 bad char, 10 digit overflow, 11 first char not a letter
//   tx_data    out  echo byte to TX FIFO
//   tx_wr      out  TX FIFO write_enable pulse
//   tx_full    in   TX FIFO full flag
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | wait for RX FIFO non-empty, pulse fifo_rd
// S_FETCH | RX FIFO output valid, capture it into byte_q
// S_PROC  | classify byte_q and update line state / outputs
// S_ECHO  | (echo build) write byte_q to TX FIFO once it has room
// S_EMIT  | cmd_valid high until the consumer takes it
// -----------------------------------------------------------------------------
module zrb_bt_cmd_parser #(
    parameter int  MAX_DIGITS = 4,
    localparam int ARG_W      = 4 * MAX_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_code,
    output logic [ARG_W-1:0] cmd_arg,
    output logic [3:0]       cmd_ndig,
    output logic             cmd_err,
    output logic [1:0]       err_code,
    output logic [7:0]       tx_data,
    output logic             tx_wr,
    input  logic             tx_full
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PROC  = 3'd2,
`ifdef ZRB_BT_CMD_ECHO_EN
        S_ECHO  = 3'd4,
`endif
        S_EMIT  = 3'd3
    } state_t;

    state_t             state, next_state;

    logic [7:0]         byte_q;
    logic               has_cmd;
    logic               err_flag;
    logic [1:0]         err_reason;
    logic [3:0]         digit_cnt;
    logic [ARG_W-1:0]   arg_acc;
    logic [7:0]         letter_q;

    logic               is_term, is_space, is_letter, is_dec, is_hex_alpha, is_hex;
    logic [3:0]         nibble;
    logic               line_ok, line_bad, clear_line;

    // ---------------- byte classification ----------------
    always_comb begin
        is_term      = (byte_q == 8'h0D) || (byte_q == 8'h0A);
        is_space     = (byte_q == 8'h20);
        is_letter    = ((byte_q >= 8'h41) && (byte_q <= 8'h5A)) ||
                       ((byte_q >= 8'h61) && (byte_q <= 8'h7A));
        is_dec       = (byte_q >= 8'h30) && (byte_q <= 8'h39);
        is_hex_alpha = ((byte_q >= 8'h41) && (byte_q <= 8'h46)) ||
                       ((byte_q >= 8'h61) && (byte_q <= 8'h66));
        is_hex       = is_dec || is_hex_alpha;
        // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
        nibble       = 4'h0;
        if (is_dec)
            nibble = byte_q[3:0];
        else if (is_hex_alpha)
            nibble = byte_q[3:0] + 4'd9;
    end

    assign line_ok    = (state == S_PROC) && is_term && has_cmd && !err_flag;
    assign line_bad   = (state == S_PROC) && is_term && has_cmd &&  err_flag;
    assign clear_line = line_bad || ((state == S_EMIT) && cmd_ready);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

`ifdef ZRB_BT_CMD_ECHO_EN
    logic emit_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            emit_pending <= 1'b0;
        else if (state == S_PROC)
            emit_pending <= line_ok;
    end
`else
    logic tx_full_unused;
    assign tx_full_unused = tx_full;
`endif

    // ---------------- next state / combinational outputs ----------------
    always_comb begin
        next_state = state;
        // Gate with reset so the FIFO is never popped while we are held in reset.
        fifo_rd    = 1'b0;
        cmd_valid  = 1'b0;
        tx_wr      = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !reset) begin
                    fifo_rd    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FETCH: next_state = S_PROC;
            S_PROC: begin
`ifdef ZRB_BT_CMD_ECHO_EN
                next_state = S_ECHO;
`else
                next_state = line_ok ? S_EMIT : S_IDLE;
`endif
            end
`ifdef ZRB_BT_CMD_ECHO_EN
            S_ECHO: begin
                tx_data = byte_q;
                if (!tx_full) begin
                    tx_wr      = 1'b1;
                    next_state = emit_pending ? S_EMIT : S_IDLE;
                end
            end
`endif
            S_EMIT: begin
                cmd_valid = 1'b1;
                if (cmd_ready)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- line state and registered outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q     <= '0;
            has_cmd    <= 1'b0;
            err_flag   <= 1'b0;
            err_reason <= 2'b00;
            digit_cnt  <= '0;
            arg_acc    <= '0;
            letter_q   <= '0;
            cmd_code   <= '0;
            cmd_arg    <= '0;
            cmd_ndig   <= '0;
            cmd_err    <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            cmd_err <= 1'b0;

            if (state == S_FETCH)
                byte_q <= fifo_data;

            if (state == S_PROC) begin
                if (is_term) begin
                    if (line_bad) begin
                        cmd_err  <= 1'b1;
                        err_code <= err_reason;
                    end else if (line_ok) begin
                        cmd_code <= letter_q;
                        cmd_arg  <= arg_acc;
                        cmd_ndig <= digit_cnt;
                    end
                end else if (!is_space) begin
                    if (!has_cmd) begin
                        // A bad first byte still marks the line as started so
                        // the rest of it is swallowed up to the terminator.
                        has_cmd <= 1'b1;
                        if (is_letter) begin
                            letter_q <= byte_q & 8'hDF;
                        end else begin
                            err_flag   <= 1'b1;
                            err_reason <= 2'b11;
                        end
                    end else if (is_hex) begin
                        if (digit_cnt < 4'(MAX_DIGITS)) begin
                            arg_acc   <= (arg_acc << 4) | ARG_W'(nibble);
                            digit_cnt <= digit_cnt + 4'd1;
                        end else if (!err_flag) begin
                            err_flag   <= 1'b1;
                            err_reason <= 2'b10;
                        end
                    end else if (!err_flag) begin
                        err_flag   <= 1'b1;
                        err_reason <= 2'b01;
                    end
                end
            end

            if (clear_line) begin
                has_cmd    <= 1'b0;
                err_flag   <= 1'b0;
                err_reason <= 2'b00;
                digit_cnt  <= '0;
                arg_acc    <= '0;
                letter_q   <= '0;
            end
        end
    end

endmodule
